// File: rtl/mem_copier_pkg.sv
// Shared types for the memmove-style block copier: FSM state encoding and copy direction.
package mem_copier_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

endpackage

// File: rtl/mem_copier_addr_gen.sv
// Source/destination address registers and remaining-word counter for mem_copier.
// Loads start addresses (last word when descending) and steps both by +/-1 per copied word.
module mem_copier_addr_gen
  import mem_copier_pkg::*;
#(
  parameter int ADDRSIZE = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                step,
  input  logic                dir,
  input  logic [ADDRSIZE-1:0] src_in,
  input  logic [ADDRSIZE-1:0] dst_in,
  input  logic [ADDRSIZE:0]   len_in,
  output logic [ADDRSIZE-1:0] src,
  output logic [ADDRSIZE-1:0] dst,
  output logic                last
);

  localparam int AW = ADDRSIZE + 1;

  logic                dir_q;
  logic [ADDRSIZE:0]   remaining;

  always_ff @(posedge clk) begin
    if (rst) begin
      src       <= '0;
      dst       <= '0;
      remaining <= '0;
      dir_q     <= DIR_ASC;
    end else if (load) begin
      dir_q     <= dir;
      remaining <= len_in;
      // Descending copies start from the last word of each region.
      if (dir == DIR_DESC) begin
        src <= ADDRSIZE'({1'b0, src_in} + len_in - AW'(1));
        dst <= ADDRSIZE'({1'b0, dst_in} + len_in - AW'(1));
      end else begin
        src <= src_in;
        dst <= dst_in;
      end
    end else if (step) begin
      remaining <= remaining - AW'(1);
      if (dir_q == DIR_DESC) begin
        src <= src - ADDRSIZE'(1);
        dst <= dst - ADDRSIZE'(1);
      end else begin
        src <= src + ADDRSIZE'(1);
        dst <= dst + ADDRSIZE'(1);
      end
    end
  end

  assign last = (remaining == AW'(1));

endmodule

// File: rtl/mem_copier.sv
// Block-copy initiator for mem_mod with memmove overlap semantics; one word per READ+WRITE pair.
// Optional fill mode (fill_mode/fill_data ports) is enabled by defining MEM_COPIER_FILL_EN.
module mem_copier
  import mem_copier_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_ADDR   = 16,
  parameter int ADDRSIZE   = $clog2(MAX_ADDR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDRSIZE-1:0]   src_addr,
  input  logic [ADDRSIZE-1:0]   dst_addr,
  input  logic [ADDRSIZE:0]     len,
`ifdef MEM_COPIER_FILL_EN
  input  logic                  fill_mode,
  input  logic [DATA_WIDTH-1:0] fill_data,
`endif
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDRSIZE-1:0]   mem_rd_addr,
  output logic [ADDRSIZE-1:0]   mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int AW = ADDRSIZE + 1;
  localparam logic [ADDRSIZE:0] MAX_A = AW'(MAX_ADDR);

  state_t state, state_nxt;

  logic                  err_q;
  logic                  fill_q;
  logic [DATA_WIDTH-1:0] fill_data_q;
  logic                  fill_in;
  logic [DATA_WIDTH-1:0] fill_data_in;
  logic [ADDRSIZE:0]     src_end;
  logic [ADDRSIZE:0]     dst_end;
  logic                  range_err;
  logic                  dir;
  logic                  load;
  logic                  step;
  logic                  last;
  logic [ADDRSIZE-1:0]   cur_src;
  logic [ADDRSIZE-1:0]   cur_dst;

`ifdef MEM_COPIER_FILL_EN
  assign fill_in      = fill_mode;
  assign fill_data_in = fill_data;
`else
  assign fill_in      = 1'b0;
  assign fill_data_in = '0;
`endif

  assign src_end   = {1'b0, src_addr} + len;
  assign dst_end   = {1'b0, dst_addr} + len;
  // Fill never touches the source region, so its range is not checked.
  assign range_err = (!fill_in && (src_end > MAX_A)) || (dst_end > MAX_A);
  assign dir       = (!fill_in && (dst_addr > src_addr) && ({1'b0, dst_addr} < src_end))
                     ? DIR_DESC : DIR_ASC;
  assign load      = (state == IDLE) && start;
  assign step      = (state == WRITE);

  mem_copier_addr_gen #(
    .ADDRSIZE (ADDRSIZE)
  ) u_addr_gen (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (step),
    .dir    (dir),
    .src_in (src_addr),
    .dst_in (dst_addr),
    .len_in (len),
    .src    (cur_src),
    .dst    (cur_dst),
    .last   (last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q       <= 1'b0;
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else if (load) begin
      err_q       <= range_err;
      fill_q      <= fill_in;
      fill_data_q <= fill_data_in;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (range_err || (len == '0)) state_nxt = DONE;
          else if (fill_in)             state_nxt = WRITE;
          else                          state_nxt = READ;
        end
      end
      READ:  state_nxt = WRITE;
      WRITE: begin
        if (last)        state_nxt = DONE;
        else if (fill_q) state_nxt = WRITE;
        else             state_nxt = READ;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_rd_addr = '0;
    mem_wr_addr = '0;
    mem_wr_data = '0;
    unique case (state)
      READ: begin
        busy        = 1'b1;
        mem_rd_en   = 1'b1;
        mem_rd_addr = cur_src;
      end
      WRITE: begin
        busy        = 1'b1;
        mem_wr_en   = 1'b1;
        mem_wr_addr = cur_dst;
        mem_wr_data = fill_q ? fill_data_q : mem_rd_data;
      end
      DONE: begin
        done = 1'b1;
        err  = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_copier.sv
// Bench for mem_copier: behavioural registered-read memory plus a memmove reference model.
module tb_mem_copier;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] src_addr = '0;
  logic [3:0] dst_addr = '0;
  logic [4:0] len = '0;
  logic       fill_mode = 1'b0;
  logic [7:0] fill_data = '0;
  logic       busy, done, err, mem_rd_en, mem_wr_en;
  logic [3:0] mem_rd_addr, mem_wr_addr;
  logic [7:0] mem_wr_data;
  logic [7:0] mem_rd_data = '0;

  logic [7:0] mem [16];
  logic [7:0] init_img [16];
  logic       load_img = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mem_copier #(.DATA_WIDTH(8), .MAX_ADDR(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .len         (len),
`ifdef MEM_COPIER_FILL_EN
    .fill_mode   (fill_mode),
    .fill_data   (fill_data),
`endif
    .busy        (busy),
    .done        (done),
    .err         (err),
    .mem_rd_en   (mem_rd_en),
    .mem_wr_en   (mem_wr_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  // mem_mod stand-in: registered read, write on the same edge.
  always @(posedge clk) begin
    if (load_img) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_img[i];
    end else begin
      if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
      if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
    end
  end

  task automatic preload_random();
    for (int i = 0; i < 16; i++) init_img[i] = 8'($urandom);
    @(negedge clk); load_img = 1'b1;
    @(negedge clk); load_img = 1'b0;
  endtask

  // Launches one request and observes the DUT until done or a cycle budget runs out.
  task automatic run_copy(input int s, input int d, input int l, input bit fm, input logic [7:0] fd,
                          output int done_cyc, output bit err_seen, output int busy_cnt,
                          output int rd_cnt, output int wr_cnt, output int ovl, output int first_rd);
    done_cyc = -1; err_seen = 0; busy_cnt = 0; rd_cnt = 0; wr_cnt = 0; ovl = 0; first_rd = -1;
    @(negedge clk);
    src_addr = 4'(s); dst_addr = 4'(d); len = 5'(l); fill_mode = fm; fill_data = fd; start = 1'b1;
    @(negedge clk);
    start = 1'b0; fill_mode = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (busy) busy_cnt++;
      if (mem_rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = int'(mem_rd_addr);
      end
      if (mem_wr_en) wr_cnt++;
      if (mem_rd_en && mem_wr_en) ovl++;
      if (done) begin
        done_cyc = c; err_seen = err;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Expected memory after a memmove-style copy from the preloaded image.
  function automatic bit mem_matches_copy(input int s, input int d, input int l);
    logic [7:0] expd [16];
    logic [7:0] tmp [16];
    for (int i = 0; i < 16; i++) expd[i] = init_img[i];
    if (s + l <= 16 && d + l <= 16) begin
      for (int i = 0; i < l; i++) tmp[i] = init_img[s + i];
      for (int i = 0; i < l; i++) expd[d + i] = tmp[i];
    end
    for (int i = 0; i < 16; i++) if (mem[i] !== expd[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, done, err, mem_rd_en, mem_wr_en} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl: got %b want 00000", {busy, done, err, mem_rd_en, mem_wr_en});
    end
    tests++;
    if ({mem_rd_addr, mem_wr_addr, mem_wr_data} !== 16'h0) begin
      fails++; $display("FAIL reset_bus: got %h want 0000", {mem_rd_addr, mem_wr_addr, mem_wr_data});
    end
  endtask

  task automatic test_copy_case(input string name, input int s, input int d, input int l, input int exp_first);
    int dc, bc, rc, wc, ov, fr; bit es;
    preload_random();
    run_copy(s, d, l, 1'b0, 8'h00, dc, es, bc, rc, wc, ov, fr);
    tests++;
    if (dc !== 2 * l + 1 || es !== 1'b0) begin
      fails++; $display("FAIL %s_done: cycle %0d err %0d, want cycle %0d err 0", name, dc, es, 2 * l + 1);
    end
    tests++;
    if (bc !== 2 * l || rc !== l || wc !== l || ov !== 0) begin
      fails++; $display("FAIL %s_activity: busy %0d rd %0d wr %0d ovl %0d, want %0d/%0d/%0d/0", name, bc, rc, wc, ov, 2 * l, l, l);
    end
    tests++;
    if (fr !== exp_first) begin
      fails++; $display("FAIL %s_first_rd: got %0d want %0d", name, fr, exp_first);
    end
    tests++;
    if (!mem_matches_copy(s, d, l)) begin
      fails++; $display("FAIL %s_mem: memory contents differ from memmove result", name);
    end
  endtask

  task automatic test_basic();
    test_copy_case("basic", 2, 8, 3, 2);
  endtask

  task automatic test_overlap();
    test_copy_case("ovl_up", 0, 2, 4, 3);
    test_copy_case("ovl_down", 4, 2, 4, 4);
  endtask

  task automatic test_range_err();
    int dc, bc, rc, wc, ov, fr; bit es;
    preload_random();
    run_copy(14, 0, 3, 1'b0, 8'h00, dc, es, bc, rc, wc, ov, fr);
    tests++;
    if (dc !== 1 || es !== 1'b1 || rc + wc + bc !== 0) begin
      fails++; $display("FAIL range_err: cycle %0d err %0d acts %0d, want 1/1/0", dc, es, rc + wc + bc);
    end
    run_copy(5, 9, 0, 1'b0, 8'h00, dc, es, bc, rc, wc, ov, fr);
    tests++;
    if (dc !== 1 || es !== 1'b0 || rc + wc + bc !== 0) begin
      fails++; $display("FAIL len_zero: cycle %0d err %0d acts %0d, want 1/0/0", dc, es, rc + wc + bc);
    end
    tests++;
    if (!mem_matches_copy(0, 0, 0)) begin
      fails++; $display("FAIL noaccess_mem: memory changed without access");
    end
  endtask

  task automatic test_random();
    int dc, bc, rc, wc, ov, fr; bit es;
    for (int n = 0; n < 40; n++) begin
      int s, d, l, ec, el; bit ee;
      s = $urandom_range(0, 15); d = $urandom_range(0, 15); l = $urandom_range(0, 16);
      ee = (s + l > 16) || (d + l > 16);
      el = ee ? 0 : l;
      ec = (el == 0) ? 1 : 2 * el + 1;
      preload_random();
      run_copy(s, d, l, 1'b0, 8'h00, dc, es, bc, rc, wc, ov, fr);
      tests++;
      if (dc !== ec || es !== ee || rc !== el || wc !== el || ov !== 0) begin
        fails++; $display("FAIL rand_ctrl s=%0d d=%0d l=%0d: cyc %0d err %0d rd %0d wr %0d, want %0d/%0d/%0d", s, d, l, dc, es, rc, wc, ec, ee, el);
      end
      tests++;
      if (!mem_matches_copy(s, d, l)) begin
        fails++; $display("FAIL rand_mem s=%0d d=%0d l=%0d: memory differs from memmove", s, d, l);
      end
    end
  endtask

  task automatic test_ignored_start();
    int dc;
    dc = -1;
    preload_random();
    @(negedge clk);
    src_addr = 4'd2; dst_addr = 4'd8; len = 5'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 2) begin src_addr = 4'd0; dst_addr = 4'd0; len = 5'd1; start = 1'b1; end
      if (c == 3) start = 1'b0;
      if (done) begin dc = c; break; end
      @(negedge clk);
    end
    start = 1'b1;  // also held through DONE: must not relaunch
    @(negedge clk);
    start = 1'b0;
    tests++;
    if (dc !== 7) begin
      fails++; $display("FAIL ign_start_done: got cycle %0d want 7", dc);
    end
    tests++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL ign_start_done_state: busy %0d done %0d want 0 0", busy, done);
    end
    tests++;
    if (!mem_matches_copy(2, 8, 3)) begin
      fails++; $display("FAIL ign_start_mem: memory differs from copy 2->8 len 3");
    end
  endtask

  task automatic test_reset_mid();
    int seen_done;
    seen_done = 0;
    preload_random();
    @(negedge clk);
    src_addr = 4'd0; dst_addr = 4'd8; len = 5'd4; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    tests++;
    if ({busy, done, err, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data} !== 21'h0) begin
      fails++; $display("FAIL midrst_outputs: got %h want 0", {busy, done, err, mem_rd_en, mem_wr_en, mem_rd_addr, mem_wr_addr, mem_wr_data});
    end
    for (int c = 0; c < 10; c++) begin
      if (done || busy) seen_done++;
      @(negedge clk);
    end
    tests++;
    if (seen_done !== 0) begin
      fails++; $display("FAIL midrst_no_done: got %0d active cycles want 0", seen_done);
    end
    tests++;
    if (mem[8] !== init_img[0] || mem[9] !== init_img[9] || mem[10] !== init_img[10] || mem[11] !== init_img[11]) begin
      fails++; $display("FAIL midrst_mem: got %h %h %h %h want %h %h %h %h", mem[8], mem[9], mem[10], mem[11],
                        init_img[0], init_img[9], init_img[10], init_img[11]);
    end
  endtask

`ifdef MEM_COPIER_FILL_EN
  task automatic test_fill();
    int dc, bc, rc, wc, ov, fr, bad; bit es;
    bad = 0;
    preload_random();
    run_copy(7, 0, 16, 1'b1, 8'hA5, dc, es, bc, rc, wc, ov, fr);
    for (int i = 0; i < 16; i++) if (mem[i] !== 8'hA5) bad++;
    tests++;
    if (dc !== 17 || es !== 1'b0 || rc !== 0 || wc !== 16 || bc !== 16) begin
      fails++; $display("FAIL fill_ctrl: cyc %0d err %0d rd %0d wr %0d busy %0d, want 17/0/0/16/16", dc, es, rc, wc, bc);
    end
    tests++;
    if (bad !== 0) begin
      fails++; $display("FAIL fill_mem: got %0d wrong words want 0", bad);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_overlap();
    test_range_err();
    test_ignored_start();
    test_reset_mid();
    test_random();
`ifdef MEM_COPIER_FILL_EN
    test_fill();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
